// File: rtl/tri_pkg.sv
// Shared constants and types for the point-in-triangle test sequencer.
package tri_pkg;

  localparam int unsigned COORD_W_DEFAULT = 11;

  // Two-bit edge sign encodings
  localparam logic [1:0] SIGN_ZERO = 2'b00;
  localparam logic [1:0] SIGN_POS  = 2'b01;
  localparam logic [1:0] SIGN_NEG  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_E1   = 3'd1,
    ST_E2   = 3'd2,
    ST_E3   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/edge_eval.sv
// Combinational edge function: sign of (ax-cx)*(by-cy)-(bx-cx)*(ay-cy).
module edge_eval
  import tri_pkg::*;
#(
  parameter int unsigned W = COORD_W_DEFAULT
) (
  input  logic [W-1:0] ax,
  input  logic [W-1:0] ay,
  input  logic [W-1:0] bx,
  input  logic [W-1:0] by,
  input  logic [W-1:0] cx,
  input  logic [W-1:0] cy,
  output logic [1:0]   sign
);

  localparam int unsigned DW = W + 1;
  localparam int unsigned PW = 2 * W + 2;
  localparam int unsigned RW = 2 * W + 3;

  logic signed [DW-1:0] d_ac_x;
  logic signed [DW-1:0] d_bc_y;
  logic signed [DW-1:0] d_bc_x;
  logic signed [DW-1:0] d_ac_y;
  logic signed [PW-1:0] prod_a;
  logic signed [PW-1:0] prod_b;
  logic signed [RW-1:0] value;

  // Widths are chosen so no intermediate can overflow for any coordinates
  always_comb begin
    d_ac_x = $signed({1'b0, ax}) - $signed({1'b0, cx});
    d_bc_y = $signed({1'b0, by}) - $signed({1'b0, cy});
    d_bc_x = $signed({1'b0, bx}) - $signed({1'b0, cx});
    d_ac_y = $signed({1'b0, ay}) - $signed({1'b0, cy});
    prod_a = PW'(d_ac_x) * PW'(d_bc_y);
    prod_b = PW'(d_bc_x) * PW'(d_ac_y);
    value  = RW'(prod_a) - RW'(prod_b);
    sign   = SIGN_ZERO;
    if (value[RW-1]) begin
      sign = SIGN_NEG;
    end else if (value != '0) begin
      sign = SIGN_POS;
    end
  end

endmodule

// File: rtl/tri_test_seq.sv
// Point-in-triangle sequencer: one shared edge evaluator stepped over three edges.
module tri_test_seq
  import tri_pkg::*;
#(
  parameter int unsigned COORD_W = COORD_W_DEFAULT,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3*COORD_W-1:0] in_vx,
  input  logic [3*COORD_W-1:0] in_vy,
  input  logic [COORD_W-1:0]   in_ptx,
  input  logic [COORD_W-1:0]   in_pty,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_inside,
  output logic [5:0]           out_edge_sign,
  output logic [CNT_W-1:0]     out_count
);

  localparam int unsigned W = COORD_W;

  state_t state;
  state_t state_next;

  logic [3*W-1:0] vx_q;
  logic [3*W-1:0] vy_q;
  logic [W-1:0]   ptx_q;
  logic [W-1:0]   pty_q;
  logic [1:0]     s1_q;
  logic [1:0]     s2_q;
  logic [1:0]     s3_q;

  logic [W-1:0]   bx_c;
  logic [W-1:0]   by_c;
  logic [W-1:0]   cx_c;
  logic [W-1:0]   cy_c;
  logic [1:0]     ev_sign_c;
  logic           any_pos_c;
  logic           any_neg_c;
  logic           inside_c;
  logic           accept_c;
  logic           complete_c;

  assign accept_c   = in_valid && in_ready;
  assign complete_c = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept_c) state_next = ST_E1;
      ST_E1:   state_next = ST_E2;
      ST_E2:   state_next = ST_E3;
      ST_E3:   state_next = ST_DONE;
      ST_DONE: if (complete_c) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Select the edge vertices (b, c) for the current evaluation step
  always_comb begin
    bx_c = vx_q[W-1:0];
    by_c = vy_q[W-1:0];
    cx_c = vx_q[2*W-1:W];
    cy_c = vy_q[2*W-1:W];
    case (state)
      ST_E2: begin
        bx_c = vx_q[2*W-1:W];
        by_c = vy_q[2*W-1:W];
        cx_c = vx_q[3*W-1:2*W];
        cy_c = vy_q[3*W-1:2*W];
      end
      ST_E3: begin
        bx_c = vx_q[3*W-1:2*W];
        by_c = vy_q[3*W-1:2*W];
        cx_c = vx_q[W-1:0];
        cy_c = vy_q[W-1:0];
      end
      default: ;
    endcase
  end

  edge_eval #(.W(W)) u_edge_eval (
    .ax   (ptx_q),
    .ay   (pty_q),
    .bx   (bx_c),
    .by   (by_c),
    .cx   (cx_c),
    .cy   (cy_c),
    .sign (ev_sign_c)
  );

  // Zero edges agree with either sign, so only a pos/neg mix means outside
  always_comb begin
    any_pos_c = (s1_q == SIGN_POS) || (s2_q == SIGN_POS) || (s3_q == SIGN_POS);
    any_neg_c = (s1_q == SIGN_NEG) || (s2_q == SIGN_NEG) || (s3_q == SIGN_NEG);
    inside_c  = !(any_pos_c && any_neg_c);
  end

  // Capture, per-edge sign storage, result publication and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vx_q          <= '0;
      vy_q          <= '0;
      ptx_q         <= '0;
      pty_q         <= '0;
      s1_q          <= SIGN_ZERO;
      s2_q          <= SIGN_ZERO;
      s3_q          <= SIGN_ZERO;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_inside    <= 1'b0;
      out_edge_sign <= '0;
      out_count     <= '0;
    end else begin
      in_ready <= (state_next == ST_IDLE);
      if (accept_c) begin
        vx_q  <= in_vx;
        vy_q  <= in_vy;
        ptx_q <= in_ptx;
        pty_q <= in_pty;
      end
      case (state)
        ST_E1: s1_q <= ev_sign_c;
        ST_E2: s2_q <= ev_sign_c;
        ST_E3: s3_q <= ev_sign_c;
        ST_DONE: begin
          // First DONE cycle publishes; results then hold until consumed
          if (!out_valid) begin
            out_valid     <= 1'b1;
            out_inside    <= inside_c;
            out_edge_sign <= {s3_q, s2_q, s1_q};
          end else if (out_ready) begin
            out_valid <= 1'b0;
            out_count <= out_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_test_seq.sv
// Self-checking bench for tri_test_seq with a reference point-in-triangle model.
module tb_tri_test_seq;

  localparam int unsigned W     = 11;
  localparam int unsigned CW    = 4;
  localparam int unsigned VW    = 3 * W;
  localparam int          MAXC  = 2047;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_vx;
  logic [VW-1:0] in_vy;
  logic [W-1:0]  in_ptx;
  logic [W-1:0]  in_pty;
  logic          out_valid;
  logic          out_ready;
  logic          out_inside;
  logic [5:0]    out_edge_sign;
  logic [CW-1:0] out_count;

  int passed = 0;
  int total  = 0;
  int exp_count = 0;

  tri_test_seq #(.COORD_W(W), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_vx         (in_vx),
    .in_vy         (in_vy),
    .in_ptx        (in_ptx),
    .in_pty        (in_pty),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inside    (out_inside),
    .out_edge_sign (out_edge_sign),
    .out_count     (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: signed area of (a,b,c) in plain integer arithmetic
  function automatic longint edge_val(input longint ax, ay, bx, by, cx, cy);
    return (ax - cx) * (by - cy) - (bx - cx) * (ay - cy);
  endfunction

  function automatic logic [1:0] sign_of(input longint v);
    if (v > 0) return 2'b01;
    if (v < 0) return 2'b10;
    return 2'b00;
  endfunction

  task automatic scramble_inputs();
    in_vx  = VW'({$urandom, $urandom});
    in_vy  = VW'({$urandom, $urandom});
    in_ptx = W'($urandom);
    in_pty = W'($urandom);
  endtask

  task automatic run_test(input int x1, y1, x2, y2, x3, y3, px, py, input int hold);
    longint     e1, e2, e3;
    logic [5:0] exp_sign;
    logic       exp_in;
    int         lat;
    e1 = edge_val(px, py, x1, y1, x2, y2);
    e2 = edge_val(px, py, x2, y2, x3, y3);
    e3 = edge_val(px, py, x3, y3, x1, y1);
    exp_sign = {sign_of(e3), sign_of(e2), sign_of(e1)};
    exp_in = !(((e1 > 0) || (e2 > 0) || (e3 > 0)) && ((e1 < 0) || (e2 < 0) || (e3 < 0)));

    check("ready_before_accept", 32'(in_ready), 32'd1);
    in_vx    = {W'(x3), W'(x2), W'(x1)};
    in_vy    = {W'(y3), W'(y2), W'(y1)};
    in_ptx   = W'(px);
    in_pty   = W'(py);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble_inputs();

    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      if (lat == 0) begin
        @(posedge clk);
        #1;
        if (out_valid) lat = n;
      end
    end
    check("latency", 32'(lat), 32'd4);
    check("inside", 32'(out_inside), 32'(exp_in));
    check("edge_sign", 32'(out_edge_sign), 32'(exp_sign));
    check("busy_not_ready", 32'(in_ready), 32'd0);

    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_inside", 32'(out_inside), 32'(exp_in));
      check("hold_sign", 32'(out_edge_sign), 32'(exp_sign));
      check("hold_not_ready", 32'(in_ready), 32'd0);
    end

    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    exp_count = (exp_count + 1) % 16;
    check("valid_dropped", 32'(out_valid), 32'd0);
    check("ready_after_done", 32'(in_ready), 32'd1);
    check("count", 32'(out_count), 32'(exp_count));
  endtask

  task automatic check_reset_values();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_inside", 32'(out_inside), 32'd0);
    check("rst_sign", 32'(out_edge_sign), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
  endtask

  initial begin
    int mode;
    int c[8];
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_vx     = '0;
    in_vy     = '0;
    in_ptx    = '0;
    in_pty    = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset while evaluating the second edge discards the test
    in_vx    = {W'(0), W'(100), W'(0)};
    in_vy    = {W'(100), W'(0), W'(0)};
    in_ptx   = W'(10);
    in_pty   = W'(10);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check_reset_values();
    exp_count = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases on the reference right triangle
    run_test(0, 0, 100, 0, 0, 100, 10, 10, 0);
    run_test(0, 0, 100, 0, 0, 100, 200, 200, 0);
    run_test(0, 0, 100, 0, 0, 100, 50, 0, 5);
    run_test(0, 0, 100, 0, 0, 100, 10, 10, 2);
    run_test(5, 5, 5, 5, 5, 5, 5, 5, 0);

    // Coordinate extremes
    run_test(0, 0, MAXC, 0, 0, MAXC, MAXC, MAXC, 1);
    run_test(MAXC, MAXC, 0, MAXC, MAXC, 0, 0, 0, 0);
    run_test(0, MAXC, MAXC, 0, 0, 0, 0, 0, 0);
    run_test(MAXC, 0, 0, MAXC, MAXC, MAXC, 0, 0, 0);

    // Randomized tests; counter wraps several times
    repeat (30) begin
      mode = int'($urandom_range(0, 2));
      for (int k = 0; k < 8; k++) begin
        if (mode == 0)      c[k] = int'($urandom_range(0, MAXC));
        else if (mode == 1) c[k] = int'($urandom_range(0, 6));
        else                c[k] = ($urandom_range(0, 1) == 1) ? MAXC : 0;
      end
      run_test(c[0], c[1], c[2], c[3], c[4], c[5], c[6], c[7], int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tri_test_seq.md
TRI_TEST_SEQ -- requirements
Module: tri_test_seq

Interface
REQ-001 SHALL have parameter COORD_W, default 11, unsigned coordinate width.
REQ-002 SHALL have parameter CNT_W, default 16, completed-test counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  request valid.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-007 SHALL have port in_vx  input  3*COORD_W  {p3x,p2x,p1x} triangle vertex x.
REQ-008 SHALL have port in_vy  input  3*COORD_W  {p3y,p2y,p1y} triangle vertex y.
REQ-009 SHALL have port in_ptx  input  COORD_W  test point x.
REQ-010 SHALL have port in_pty  input  COORD_W  test point y.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready.
REQ-013 SHALL have port out_inside  output  1  1 = point inside or on boundary.
REQ-014 SHALL have port out_edge_sign  output  6  {e3,e2,e1}, 2 bits each: 01 pos, 10 neg, 00 zero.
REQ-015 SHALL have port out_count  output  CNT_W  number of results consumed, wrapping.

Function
REQ-016 SHALL capture all coordinate inputs into internal registers on the accepting handshake; inputs are ignored otherwise.
REQ-017 SHALL use one shared edge evaluator, time-multiplexed over three edges: e1=(pt,p1,p2), e2=(pt,p2,p3), e3=(pt,p3,p1).
REQ-018 Edge value for (a,b,c) SHALL be (ax-cx)*(by-cy)-(bx-cx)*(ay-cy), with differences sign-extended to COORD_W+1 bits, products 2*COORD_W+2 bits, result 2*COORD_W+3 bits signed; no overflow for any input.
REQ-019 FSM states SHALL be IDLE, E1, E2, E3, DONE; IDLE->E1 on handshake, E1->E2->E3->DONE unconditionally, DONE->IDLE on out_ready.
REQ-020 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-021 Latency SHALL be fixed: out_valid rises 4 cycles after the accepting edge.
REQ-022 out_inside SHALL equal NOT(any edge positive AND any edge negative); zero edges are compatible with either sign; all-zero (degenerate) gives 1.
REQ-023 out_inside and out_edge_sign SHALL be stable while out_valid is high and out_ready low.
REQ-024 out_count SHALL increment by 1 on each output handshake, wrapping 2^CNT_W-1 -> 0.
REQ-025 Next request SHALL be acceptable the cycle after the output handshake (no same-cycle accept/complete).

Reset
REQ-026 On rst_n low, state SHALL go to IDLE immediately; in_ready=1 (after reset), out_valid=0, out_inside=0, out_edge_sign=0, out_count=0, captured registers 0.
REQ-027 Reset asserted mid-test (E1..DONE) SHALL discard the test with no counter increment.

Structure
REQ-028 Package tri_pkg SHALL hold COORD_W default, edge-sign encodings, and the state enum.
REQ-029 Edge evaluator SHALL be a combinational sub-module edge_eval (inputs a,b,c coordinates; outputs 2-bit sign), one instance.

Verification
REQ-030 Tri (0,0),(100,0),(0,100), pt (10,10) -> out_inside=1, out_edge_sign=010101, out_valid 4 cycles after accept.
REQ-031 Same tri, pt (200,200) -> e1 +20000, e2 -30000: out_inside=0, e2 sign 10.
REQ-032 Same tri, pt (50,0) -> out_edge_sign=010100, out_inside=1.
REQ-033 out_ready low 5 cycles in DONE -> out_valid and outputs held, in_ready=0; second request accepted the cycle after handshake.
REQ-034 rst_n pulsed low during E2 -> outputs at reset values, out_count unchanged at 0, in_ready=1; new test then completes normally.
REQ-035 All coordinates 2047 vs 0 extremes, and CNT_W=4 with 16 results -> no arithmetic overflow, out_count wraps 15 -> 0.
